tone_synth: RTL and testbench

Square-wave synthesizer directly downstream of the note sequencer. It takes the 7-bit tone index the sequencer emits each cycle and drives the piezo/speaker pin with a 50 % duty square wave at that note's equal-tempered frequency. Pitch changes are applied only at half-period boundaries, so the speaker output never glitches.

---
 rtl/tone_synth_if.sv | 19 +
 rtl/tone_synth.sv | 118 +++++++++++
 tb/tb_tone_synth.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tone_synth_if.sv
// Tone-index input and square-wave output bundle between the note sequencer
// (master) and the tone synthesizer (slave).
interface tone_synth_if;
  logic [6:0]  tone;
  logic        mute;
  logic        speaker;
  logic        active;
  logic [20:0] half_period;

  modport master (
    output tone, mute,
    input  speaker, active, half_period
  );

  modport slave (
    input  tone, mute,
    output speaker, active, half_period
  );
endinterface

// File: rtl/tone_synth.sv
// 50 % duty square-wave synthesizer for equal-tempered notes at clk = 50 MHz.
// Pitch changes take effect only at half-period boundaries, so the output never glitches.
module tone_synth #(
  parameter int TONE_MIN = 21,
  parameter int TONE_MAX = 108
) (
  input  logic         clk,
  input  logic         rst,
  tone_synth_if.slave  syn_if
);

  localparam logic [6:0] TMIN = 7'(TONE_MIN);
  localparam logic [6:0] TMAX = 7'(TONE_MAX);

  logic [6:0]  tone_q, tone_d;
  logic [20:0] pend_q, pend_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] cur_q, cur_d;
  logic        speaker_q, speaker_d;
  logic        active_q, active_d;

  logic [3:0]  oct;
  logic [3:0]  rem;
  logic [20:0] base;

  always_comb begin
    tone_d = syn_if.tone;
    if (syn_if.mute || (syn_if.tone < TMIN) || (syn_if.tone > TMAX))
      tone_d = 7'd0;
  end

  // Octave/semitone split by threshold compare; tone_q never exceeds 127, so at most 10 octaves.
  always_comb begin
    oct = 4'd0;
    rem = tone_q[3:0];
    for (int i = 1; i <= 10; i++) begin
      if (tone_q >= 7'(12 * i)) begin
        oct = 4'(i);
        rem = 4'(tone_q - 7'(12 * i));
      end
    end
  end

  always_comb begin
    case (rem)
      4'd0:    base = 21'd1528902;
      4'd1:    base = 21'd1443093;
      4'd2:    base = 21'd1362101;
      4'd3:    base = 21'd1285651;
      4'd4:    base = 21'd1213492;
      4'd5:    base = 21'd1145381;
      4'd6:    base = 21'd1081095;
      4'd7:    base = 21'd1020421;
      4'd8:    base = 21'd963150;
      4'd9:    base = 21'd909091;
      4'd10:   base = 21'd858069;
      4'd11:   base = 21'd809908;
      default: base = 21'd0;
    endcase
  end

  // BASE holds octave 0 periods; octave n is BASE >> (n-1) since the table is one octave low.
  always_comb begin
    pend_d = 21'd0;
    if (tone_q != 7'd0)
      pend_d = base >> (oct - 4'd1);
  end

  always_comb begin
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    speaker_d = speaker_q;
    active_d  = active_q;
    if (cur_q == 21'd0) begin
      if (pend_q != 21'd0) begin
        cur_d     = pend_q;
        cnt_d     = pend_q - 21'd1;
        speaker_d = 1'b1;
        active_d  = 1'b1;
      end
    end else if (cnt_q != 21'd0) begin
      cnt_d = cnt_q - 21'd1;
    end else if (pend_q != 21'd0) begin
      cur_d     = pend_q;
      cnt_d     = pend_q - 21'd1;
      speaker_d = ~speaker_q;
    end else begin
      // Boundary with nothing pending: finish silently and return to idle.
      cur_d     = 21'd0;
      cnt_d     = 21'd0;
      speaker_d = 1'b0;
      active_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_q    <= 7'd0;
      pend_q    <= 21'd0;
      cnt_q     <= 21'd0;
      cur_q     <= 21'd0;
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      tone_q    <= tone_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      speaker_q <= speaker_d;
      active_q  <= active_d;
    end
  end

  assign syn_if.speaker     = speaker_q;
  assign syn_if.active      = active_q;
  assign syn_if.half_period = cur_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: start latency, phase lengths, boundary-only pitch
// changes, rest/mute silencing, range limits and asynchronous reset.
module tb_tone_synth;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  tone_synth_if syn_if();

  tone_synth dut (
    .clk    (clk),
    .rst    (rst),
    .syn_if (syn_if)
  );

  // Negedges until speaker is high (capped at max).
  task automatic count_to_rise(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (syn_if.speaker !== 1'b1 && n < max);
  endtask

  // Negedges until speaker leaves its current level (capped at max).
  task automatic measure_phase(input int max, output int len);
    logic lvl;
    lvl = syn_if.speaker;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (syn_if.speaker === lvl && len < max);
  endtask

  task automatic go_idle();
    @(negedge clk);
    rst = 1'b1;
    syn_if.tone = 7'd0;
    syn_if.mute = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    syn_if.tone = 7'd0;
    syn_if.mute = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (syn_if.speaker !== 1'b0) begin
      errors++; $display("FAIL reset_speaker: got %b want 0", syn_if.speaker);
    end
    checks++;
    if (syn_if.active !== 1'b0) begin
      errors++; $display("FAIL reset_active: got %b want 0", syn_if.active);
    end
    checks++;
    if (syn_if.half_period !== 21'd0) begin
      errors++; $display("FAIL reset_half_period: got %0d want 0", syn_if.half_period);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0) begin
      errors++; $display("FAIL idle_rest: speaker %b active %b want 0 0", syn_if.speaker, syn_if.active);
    end
  endtask

  task automatic test_start_and_async_reset();
    int n;
    syn_if.tone = 7'd69;
    count_to_rise(10, n);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL a4_latency: got %0d edges want 3", n);
    end
    checks++;
    if (syn_if.half_period !== 21'd56818 || syn_if.active !== 1'b1) begin
      errors++; $display("FAIL a4_half_period: got %0d active %b want 56818 1", syn_if.half_period, syn_if.active);
    end
    repeat (1000) @(negedge clk);
    checks++;
    if (syn_if.speaker !== 1'b1) begin
      errors++; $display("FAIL a4_still_high: got %b want 1", syn_if.speaker);
    end
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0 || syn_if.half_period !== 21'd0) begin
      errors++; $display("FAIL async_reset: speaker %b active %b hp %0d want 0 0 0",
                         syn_if.speaker, syn_if.active, syn_if.half_period);
    end
    @(negedge clk);
    rst = 1'b0;
    count_to_rise(10, n);
    checks++;
    if (n !== 3 || syn_if.half_period !== 21'd56818) begin
      errors++; $display("FAIL restart_after_reset: got %0d edges hp %0d want 3 56818", n, syn_if.half_period);
    end
  endtask

  task automatic test_tone_change();
    int n, r;
    go_idle();
    syn_if.tone = 7'd96;
    count_to_rise(10, n);
    checks++;
    if (n !== 3 || syn_if.half_period !== 21'd11944) begin
      errors++; $display("FAIL c7_start: got %0d edges hp %0d want 3 11944", n, syn_if.half_period);
    end
    repeat (1000) @(negedge clk);
    syn_if.tone = 7'd108;
    measure_phase(20000, r);
    checks++;
    if (1000 + r !== 11944) begin
      errors++; $display("FAIL change_old_phase: got %0d want 11944", 1000 + r);
    end
    measure_phase(20000, r);
    checks++;
    if (r !== 5972 || syn_if.speaker !== 1'b1) begin
      errors++; $display("FAIL change_new_low: got %0d speaker %b want 5972 1", r, syn_if.speaker);
    end
    measure_phase(20000, r);
    checks++;
    if (r !== 5972 || syn_if.half_period !== 21'd5972) begin
      errors++; $display("FAIL change_new_high: got %0d hp %0d want 5972 5972", r, syn_if.half_period);
    end
  endtask

  task automatic test_rest();
    int r;
    measure_phase(20000, r);
    checks++;
    if (r !== 5972) begin
      errors++; $display("FAIL c8_low_phase: got %0d want 5972", r);
    end
    repeat (100) @(negedge clk);
    syn_if.tone = 7'd0;
    repeat (10) @(negedge clk);
    checks++;
    if (syn_if.active !== 1'b1 || syn_if.half_period !== 21'd5972 || syn_if.speaker !== 1'b1) begin
      errors++; $display("FAIL rest_pending: active %b hp %0d speaker %b want 1 5972 1",
                         syn_if.active, syn_if.half_period, syn_if.speaker);
    end
    measure_phase(20000, r);
    checks++;
    if (110 + r !== 5972) begin
      errors++; $display("FAIL rest_final_high: got %0d want 5972", 110 + r);
    end
    checks++;
    if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0 || syn_if.half_period !== 21'd0) begin
      errors++; $display("FAIL rest_boundary: speaker %b active %b hp %0d want 0 0 0",
                         syn_if.speaker, syn_if.active, syn_if.half_period);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0) begin
      errors++; $display("FAIL rest_stays_silent: speaker %b active %b want 0 0", syn_if.speaker, syn_if.active);
    end
  endtask

  task automatic test_mute();
    int n, r;
    go_idle();
    syn_if.tone = 7'd108;
    count_to_rise(10, n);
    measure_phase(20000, r);
    checks++;
    if (n !== 3 || r !== 5972) begin
      errors++; $display("FAIL mute_pre_high: got %0d edges %0d clocks want 3 5972", n, r);
    end
    // Mute window straddles the end of the low phase.
    repeat (5966) @(negedge clk);
    syn_if.mute = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0 || syn_if.half_period !== 21'd0) begin
      errors++; $display("FAIL mute_silence: speaker %b active %b hp %0d want 0 0 0",
                         syn_if.speaker, syn_if.active, syn_if.half_period);
    end
    syn_if.mute = 1'b0;
    count_to_rise(10, n);
    checks++;
    if (n !== 3 || syn_if.half_period !== 21'd5972 || syn_if.active !== 1'b1) begin
      errors++; $display("FAIL unmute_restart: got %0d edges hp %0d active %b want 3 5972 1",
                         n, syn_if.half_period, syn_if.active);
    end
  endtask

  task automatic test_range();
    int tv[3] = '{21, 60, 108};
    int hv[3] = '{909091, 95556, 5972};
    int ov[2] = '{20, 109};
    int n;
    for (int i = 0; i < 3; i++) begin
      go_idle();
      syn_if.tone = 7'(tv[i]);
      count_to_rise(10, n);
      checks++;
      if (n !== 3 || syn_if.half_period !== 21'(hv[i]) || syn_if.active !== 1'b1) begin
        errors++; $display("FAIL range_tone_%0d: got %0d edges hp %0d active %b want 3 %0d 1",
                           tv[i], n, syn_if.half_period, syn_if.active, hv[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      go_idle();
      syn_if.tone = 7'(ov[i]);
      repeat (6) @(negedge clk);
      checks++;
      if (syn_if.speaker !== 1'b0 || syn_if.active !== 1'b0 || syn_if.half_period !== 21'd0) begin
        errors++; $display("FAIL out_of_range_%0d: speaker %b active %b hp %0d want 0 0 0",
                           ov[i], syn_if.speaker, syn_if.active, syn_if.half_period);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_and_async_reset();
    test_tone_change();
    test_rest();
    test_mute();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
